// File: rtl/uart_pkg.sv
// Shared definitions for the UART channel: transmitter state encoding,
// legal parameter ranges and the baud-counter width helper.
package uart_pkg;

  // Transmitter FSM states. Prefixed so the receive side can add its own.
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4,
    TX_BREAK  = 3'd5
  } tx_state_e;

  // Default bit period in clock cycles.
  localparam int DEFAULT_CLKS_PER_BIT = 87;

  // Legal configuration ranges.
  localparam int MIN_CLKS_PER_BIT = 2;
  localparam int MIN_DATA_BITS    = 5;
  localparam int MAX_DATA_BITS    = 8;
  localparam int MIN_STOP_BITS    = 1;
  localparam int MAX_STOP_BITS    = 2;

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_channel_if.sv
// Bus-side signal bundle of one transmit channel. The bus/CPU side drives
// through the master modport; the transmitter uses the slave modport.
interface uart_tx_channel_if;

  logic       i_TxEN;       // transmitter enable, gates THR writes only
  logic       i_TxReset;    // synchronous transmitter reset command
  logic       i_WR;         // one-cycle write strobe
  logic [7:0] i_Data;       // write data
  logic       i_ParityEn;   // append parity bit
  logic       i_ParityOdd;  // 1 = odd parity, 0 = even
  logic       i_Break;      // hold line in break (space)
  logic       o_TX_Serial;  // serial line, idle = 1
  logic       o_TxRDY;      // THR empty
  logic       o_TxEMT;      // THR empty and shifter idle
  logic       o_TX_Active;  // FSM not idle

  modport master (
    output i_TxEN, i_TxReset, i_WR, i_Data, i_ParityEn, i_ParityOdd, i_Break,
    input  o_TX_Serial, o_TxRDY, o_TxEMT, o_TX_Active
  );

  modport slave (
    input  i_TxEN, i_TxReset, i_WR, i_Data, i_ParityEn, i_ParityOdd, i_Break,
    output o_TX_Serial, o_TxRDY, o_TxEMT, o_TX_Active
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and wraps, pulsing o_Bit_End
// in the last cycle of each bit. i_Clear parks the count at 0 so the next
// bit starts on a clean boundary. Shared by the transmit and receive paths.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  localparam int CW           = cnt_width(CLKS_PER_BIT)
) (
  input  logic i_Clock,
  input  logic i_Rst_L,
  input  logic i_Clear,
  output logic o_Bit_End
);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = (r_count == CW'(CLKS_PER_BIT - 1));

  // Free-running bit counter; wraps at the end of each bit, held at 0 by clear.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create simulation/synthesis races.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_count <= '0;
    end else if (i_Clear || w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_Bit_End = w_last && !i_Clear;

endmodule

// File: rtl/uart_tx_channel.sv
// Transmit half of an MC68681-style serial channel: one-byte Transmit
// Holding Register (THR), shift register and framing FSM producing
// start / data (LSB first) / optional parity / stop bits, plus break
// generation and a synchronous transmitter reset command.
module uart_tx_channel
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input logic               i_Clock,
  input logic               i_Rst_L,
  uart_tx_channel_if.slave  bus
);

  // Reject illegal configurations at elaboration.
  if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_bad_clks_per_bit
    $error("uart_tx_channel: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
    $error("uart_tx_channel: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < MIN_STOP_BITS || STOP_BITS > MAX_STOP_BITS) begin : g_bad_stop_bits
    $error("uart_tx_channel: STOP_BITS must be 1 or 2");
  end

  // Registered state.
  tx_state_e              r_state;
  logic                   r_thr_full;
  logic [DATA_BITS-1:0]   r_thr;
  logic [DATA_BITS-1:0]   r_shift;
  logic [2:0]             r_bit_idx;   // data bit or stop bit index
  logic                   r_parity;    // parity bit latched at frame start
  logic                   r_par_en;    // parity enable latched at frame start
  logic                   r_tx;

  // Next-state values.
  tx_state_e              w_state_next;
  logic                   w_thr_full_next;
  logic [DATA_BITS-1:0]   w_thr_next;
  logic [DATA_BITS-1:0]   w_shift_next;
  logic [2:0]             w_bit_idx_next;
  logic                   w_parity_next;
  logic                   w_par_en_next;
  logic                   w_tx_next;
  logic                   w_load;      // move THR into the shifter this edge
  logic                   w_bit_end;
  logic                   w_baud_clear;

  // The bit timer only runs inside a timed bit; IDLE and BREAK hold it at 0
  // so the first bit after either starts a full period. A reset command
  // also clears it so an aborted frame leaves no partial count behind.
  assign w_baud_clear = (r_state == TX_IDLE) || (r_state == TX_BREAK) || bus.i_TxReset;

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .i_Clock   (i_Clock),
    .i_Rst_L   (i_Rst_L),
    .i_Clear   (w_baud_clear),
    .o_Bit_End (w_bit_end)
  );

  // Next-state, THR/shifter updates and next serial line value.
  // NOTE: every variable gets a default at the top of this block; any path
  // that left one unassigned would infer a latch.
  always_comb begin
    w_state_next    = r_state;
    w_thr_full_next = r_thr_full;
    w_thr_next      = r_thr;
    w_shift_next    = r_shift;
    w_bit_idx_next  = r_bit_idx;
    w_parity_next   = r_parity;
    w_par_en_next   = r_par_en;
    w_load          = 1'b0;
    w_tx_next       = 1'b1;

    case (r_state)
      TX_IDLE: begin
        // Break is only honoured at a frame boundary and beats a waiting byte.
        if (bus.i_Break) begin
          w_state_next = TX_BREAK;
        end else if (r_thr_full) begin
          w_load = 1'b1;
        end
      end

      TX_START: begin
        if (w_bit_end) begin
          w_state_next   = TX_DATA;
          w_bit_idx_next = '0;
        end
      end

      TX_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == 3'(DATA_BITS - 1)) begin
            w_state_next   = r_par_en ? TX_PARITY : TX_STOP;
            w_bit_idx_next = '0;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_shift_next   = r_shift >> 1;
          end
        end
      end

      TX_PARITY: begin
        if (w_bit_end) begin
          w_state_next   = TX_STOP;
          w_bit_idx_next = '0;
        end
      end

      TX_STOP: begin
        if (w_bit_end) begin
          if (r_bit_idx == 3'(STOP_BITS - 1)) begin
            // Frame boundary: break first, then back-to-back, else idle.
            if (bus.i_Break) begin
              w_state_next = TX_BREAK;
            end else if (r_thr_full) begin
              w_load = 1'b1;
            end else begin
              w_state_next = TX_IDLE;
            end
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end
      end

      TX_BREAK: begin
        // Leaving break always marks for exactly one bit time, whatever
        // STOP_BITS is, by entering STOP already on its last stop bit.
        if (!bus.i_Break) begin
          w_state_next   = TX_STOP;
          w_bit_idx_next = 3'(STOP_BITS - 1);
        end
      end

      default: begin
        w_state_next = TX_IDLE;
      end
    endcase

    // Start a frame: THR empties into the shifter, parity is frozen.
    if (w_load) begin
      w_state_next    = TX_START;
      w_thr_full_next = 1'b0;
      w_shift_next    = r_thr;
      w_parity_next   = (^r_thr) ^ bus.i_ParityOdd;
      w_par_en_next   = bus.i_ParityEn;
    end

    // CPU write: accepted only into an empty THR with the transmitter
    // enabled. A THR that is emptying on this edge still counts as full.
    if (bus.i_WR && bus.i_TxEN && !r_thr_full) begin
      w_thr_full_next = 1'b1;
      w_thr_next      = bus.i_Data[DATA_BITS-1:0];
    end

    // The line is registered, so drive the value belonging to the state
    // being entered on this edge.
    case (w_state_next)
      TX_IDLE:   w_tx_next = 1'b1;
      TX_START:  w_tx_next = 1'b0;
      TX_DATA:   w_tx_next = w_shift_next[0];
      TX_PARITY: w_tx_next = w_parity_next;
      TX_STOP:   w_tx_next = 1'b1;
      TX_BREAK:  w_tx_next = 1'b0;
      default:   w_tx_next = 1'b1;
    endcase

    // Transmitter reset command overrides everything, including a write.
    if (bus.i_TxReset) begin
      w_state_next    = TX_IDLE;
      w_thr_full_next = 1'b0;
      w_thr_next      = '0;
      w_shift_next    = '0;
      w_bit_idx_next  = '0;
      w_parity_next   = 1'b0;
      w_par_en_next   = 1'b0;
      w_tx_next       = 1'b1;
    end
  end

  // State register for the FSM, THR, shifter and serial line.
  // NOTE: the THR data and shifter are reset along with the control flops;
  // they are a handful of bits, not a RAM, so a defined value is free.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state    <= TX_IDLE;
      r_thr_full <= 1'b0;
      r_thr      <= '0;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_parity   <= 1'b0;
      r_par_en   <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_thr_full <= w_thr_full_next;
      r_thr      <= w_thr_next;
      r_shift    <= w_shift_next;
      r_bit_idx  <= w_bit_idx_next;
      r_parity   <= w_parity_next;
      r_par_en   <= w_par_en_next;
      r_tx       <= w_tx_next;
    end
  end

  assign bus.o_TX_Serial = r_tx;
  assign bus.o_TxRDY     = !r_thr_full;
  assign bus.o_TxEMT     = !r_thr_full && (r_state == TX_IDLE);
  assign bus.o_TX_Active = (r_state != TX_IDLE);

endmodule

// File: doc/uart_tx_channel.md
Name: uart_tx_channel

Overview:
Transmit half of one MC68681-style serial channel. The CPU bus writes bytes into a one-byte Transmit Holding Register (THR). A shifter moves each byte into a serial frame: start bit, data LSB first, optional parity, then stop bit(s). The block drives TxRDY/TxEMT status for the channel status register and supports break generation and a transmitter reset command. It sits beside the channel's receive path in the UART channel wrapper and feeds the channel's TX pin and loopback muxing.

Parameters:
CLKS_PER_BIT, 87, i_Clock cycles per serial bit (>=2)
DATA_BITS, 8, data bits per character (5..8); i_Data bits above DATA_BITS-1 are ignored
STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
i_Clock  input  1  system clock, all state on rising edge
i_Rst_L  input  1  asynchronous active-low reset
i_TxEN  input  1  transmitter enable; gates THR writes only
i_TxReset  input  1  synchronous active-high transmitter reset command
i_WR  input  1  one-cycle write strobe from bus decode (cs & !rw)
i_Data  input  8  write data
i_ParityEn  input  1  1 = append parity bit
i_ParityOdd  input  1  1 = odd parity, 0 = even parity
i_Break  input  1  level request: hold line in break (space)
o_TX_Serial  output  1  serial line, registered, idle = 1
o_TxRDY  output  1  THR empty, can accept a write
o_TxEMT  output  1  THR empty and shifter idle
o_TX_Active  output  1  FSM not in IDLE

Behaviour:
- Reset (i_Rst_L=0, async): THR empty, FSM IDLE, baud counter 0. Outputs: o_TX_Serial=1, o_TxRDY=1, o_TxEMT=1, o_TX_Active=0.
- i_TxReset=1 at an edge: same state as async reset, applied synchronously. It aborts any frame in progress mid-bit, so TX returns to 1 on that edge. It wins over a simultaneous i_WR.
- Write: i_WR & i_TxEN & THR empty at edge E0 loads THR. o_TxRDY=0 after E0.
  - Write while THR full: ignored; THR keeps the old byte and no flag is raised.
  - Write with i_TxEN=0: ignored.
  - Dropping i_TxEN does not stop a frame in progress or a byte already in THR.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK. Each bit lasts exactly CLKS_PER_BIT cycles, timed by the baud counter 0..CLKS_PER_BIT-1.
- IDLE -> START: on the edge after THR becomes full (E1 for a write at E0) with i_Break=0.
  - On that edge THR moves to the shift register and THR empties (o_TxRDY=1 after E1).
  - Parity is latched as ^data[DATA_BITS-1:0] ^ i_ParityOdd.
  - o_TX_Serial=0 from E1.
  - Write-to-start latency: 2 edges.
- START -> DATA -> (PARITY if latched ParityEn) -> STOP. DATA sends DATA_BITS bits, LSB first.
- STOP lasts STOP_BITS*CLKS_PER_BIT cycles. At its final cycle:
  - THR full and no break: go directly to START, with no idle gap (back-to-back frames).
  - Otherwise: go to IDLE.
- Frame length = (1 + DATA_BITS + ParityEn + STOP_BITS) * CLKS_PER_BIT cycles.
- Break: i_Break is acted on only at a frame boundary (from IDLE, or at the end of STOP). The FSM then enters BREAK and holds o_TX_Serial=0.
  - A byte in THR waits during break.
  - On i_Break deassert, the FSM enters STOP for one bit time (marking), then follows the normal STOP exit.
  - Break asserted mid-frame: the current frame completes first.
- o_TxEMT = THR empty & FSM in IDLE. It rises on the edge the FSM enters IDLE with THR empty.
- o_TxEMT=0 while in BREAK.

Decomposition:
- Shared package uart_pkg:
  - tx state enum (IDLE, START, DATA, PARITY, STOP, BREAK)
  - default CLKS_PER_BIT and width-of-counter function ($clog2)
  - DATA_BITS/STOP_BITS legal-range constants
- One sub-module: uart_baud_gen. It is a CLKS_PER_BIT counter with clear and a bit_end pulse, reusable by the receive side.
- THR, shifter, and FSM stay in uart_tx_channel.

Test Plan:
- CLKS_PER_BIT=4, no parity, write 0x55 at edge E0:
  - TxRDY low one cycle.
  - TX=0 for cycles 1-4 after E1, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then stop=1.
  - TxEMT rises 40 cycles after E1.
- Two writes (0xA3, then 0x0F once TxRDY=1): second frame start bit immediately follows the first stop bit with zero idle cycles. A third write while THR is full is dropped; exactly two frames appear.
- ParityEn=1, Odd=0, byte 0x07: parity bit=1. With Odd=1: parity bit=0. Frame length 11 bit-times.
- i_TxReset pulsed mid-DATA of 0xFF with THR also full: TX=1 on the next edge, TxRDY=1, TxEMT=1, and no further frame is sent.
- i_Break asserted mid-frame: frame completes, then TX=0 held 20 cycles. A byte written during break is sent only after 1 bit-time of mark following deassert.
- i_TxEN=0 during write: TxRDY stays 1 and no frame is sent. Async i_Rst_L low mid-frame: outputs reach reset values without a clock edge.
